pin_serial_tx: RTL



---
 rtl/pin_serial_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pin_serial_tx.sv
// Byte-wide serial transmitter for one IO pin: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Latency: tx goes low the cycle after the accept edge; done pulses 10*CLKS_PER_BIT+1 cycles after accept (11x with parity).
// Backpressure: ready is high only in IDLE; valid seen while busy is dropped, not queued.
// Optional feature macro: PIN_SERIAL_TX_PARITY_EN inserts an even-parity bit between data and stop.
module pin_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef PIN_SERIAL_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             bit_end;
`ifdef PIN_SERIAL_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CNT_LAST);
  assign ready   = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign tx      = tx_q;
  assign done    = done_q;

  // Next-state logic; tx_d is the line level for the state being entered, so tx stays registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
`ifdef PIN_SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (valid) begin
          state_d  = START;
          cnt_d    = '0;
          bit_d    = 3'd0;
          shift_d  = data_in;
          tx_d     = 1'b0;
`ifdef PIN_SERIAL_TX_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef PIN_SERIAL_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            // shift_q[1] is the bit that lands in shift_d[0]
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef PIN_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers; reset aborts any frame and forces the line high immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef PIN_SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef PIN_SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
